// File: rtl/conway_gen_ctrl.sv
// Generation scheduler and frame-bank arbiter for the Life engine (two 4096x1 banks, ping-pong).
// Optional build macro HOST_LOAD_EN adds a host write port into the current bank while IDLE.
module conway_gen_ctrl #(
    parameter logic [15:0] PERIOD = 16'd1000,
    parameter int          GEN_W  = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             stop,
    input  logic             step,
`ifdef HOST_LOAD_EN
    input  logic             host_we,
    input  logic [11:0]      host_addr,
    input  logic             host_wdata,
`endif
    output logic             eng_rst,
    input  logic             eng_done,
    input  logic [11:0]      eng_addr_rd,
    input  logic [11:0]      eng_addr_wr,
    input  logic             eng_we_wr,
    input  logic             eng_dout,
    output logic             eng_din,
    output logic [11:0]      a_addr,
    output logic [11:0]      b_addr,
    output logic             a_we,
    output logic             b_we,
    output logic             a_wdata,
    output logic             b_wdata,
    input  logic             a_rdata,
    input  logic             b_rdata,
    input  logic             disp_req,
    input  logic [11:0]      disp_addr,
    output logic             disp_gnt,
    output logic             disp_data,
    output logic             disp_valid,
    output logic             cur_bank,
    output logic [GEN_W-1:0] gen_count,
    output logic             busy
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_SWAP = 2'd2,
        ST_WAIT = 2'd3
    } state_t;

    state_t             state_r;
    state_t             state_s;
    logic               cur_bank_r;
    logic [GEN_W-1:0]   gen_count_r;
    logic               single_r;
    logic               stop_pend_r;
    logic [15:0]        timer_r;
    logic               disp_valid_r;
    logic               disp_data_r;

    logic               host_wr_s;
    logic [11:0]        host_addr_s;
    logic               host_wdata_s;
    logic               cur_rdata_s;
    logic [11:0]        cur_addr_s;
    logic               cur_we_s;
    logic               cur_wdata_s;
    logic [11:0]        nxt_addr_s;
    logic               nxt_we_s;
    logic               nxt_wdata_s;
    logic               eng_rst_s;
    logic               eng_din_s;
    logic               busy_s;
    logic               disp_gnt_s;

`ifdef HOST_LOAD_EN
    assign host_wr_s    = host_we & (state_r == ST_IDLE);
    assign host_addr_s  = host_addr;
    assign host_wdata_s = host_wdata;
`else
    assign host_wr_s    = 1'b0;
    assign host_addr_s  = 12'd0;
    assign host_wdata_s = 1'b0;
`endif

    assign cur_rdata_s = cur_bank_r ? b_rdata : a_rdata;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state logic
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (stop) begin
                    state_s = ST_IDLE;
                end else if (start || step) begin
                    state_s = ST_RUN;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (eng_done) begin
                    state_s = ST_SWAP;
                end else begin
                    state_s = ST_RUN;
                end
            end
            ST_SWAP: begin
                if (single_r || stop_pend_r || stop) begin
                    state_s = ST_IDLE;
                end else begin
                    state_s = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (stop) begin
                    state_s = ST_IDLE;
                end else if (timer_r == 16'd0) begin
                    state_s = ST_RUN;
                end else begin
                    state_s = ST_WAIT;
                end
            end
            default: state_s = ST_IDLE;
        endcase
    end

    // Bank routing, engine control and display grant
    always_comb begin
        eng_rst_s   = 1'b1;
        eng_din_s   = 1'b0;
        busy_s      = 1'b0;
        disp_gnt_s  = 1'b0;
        cur_addr_s  = 12'd0;
        cur_we_s    = 1'b0;
        cur_wdata_s = 1'b0;
        nxt_addr_s  = 12'd0;
        nxt_we_s    = 1'b0;
        nxt_wdata_s = 1'b0;
        case (state_r)
            ST_RUN: begin
                eng_rst_s   = 1'b0;
                busy_s      = 1'b1;
                cur_addr_s  = eng_addr_rd;
                eng_din_s   = cur_rdata_s;
                nxt_addr_s  = eng_addr_wr;
                nxt_we_s    = eng_we_wr;
                nxt_wdata_s = eng_dout;
            end
            ST_SWAP: begin
                busy_s = 1'b1;
            end
            ST_IDLE: begin
                // A host write owns the current bank's single port this cycle
                if (host_wr_s) begin
                    cur_addr_s  = host_addr_s;
                    cur_we_s    = 1'b1;
                    cur_wdata_s = host_wdata_s;
                end else if (disp_req) begin
                    disp_gnt_s = 1'b1;
                    cur_addr_s = disp_addr;
                end else begin
                    disp_gnt_s = 1'b0;
                end
            end
            ST_WAIT: begin
                if (disp_req) begin
                    disp_gnt_s = 1'b1;
                    cur_addr_s = disp_addr;
                end else begin
                    disp_gnt_s = 1'b0;
                end
            end
            default: begin
                eng_rst_s = 1'b1;
            end
        endcase
    end

    // Generation bookkeeping and registered display read
    always_ff @(posedge clk) begin
        if (rst) begin
            cur_bank_r   <= 1'b0;
            gen_count_r  <= '0;
            single_r     <= 1'b0;
            stop_pend_r  <= 1'b0;
            timer_r      <= 16'd0;
            disp_valid_r <= 1'b0;
            disp_data_r  <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (!stop && (start || step)) begin
                        single_r <= ~start;
                    end
                end
                ST_RUN: begin
                    if (stop) begin
                        stop_pend_r <= 1'b1;
                    end
                end
                ST_SWAP: begin
                    cur_bank_r  <= ~cur_bank_r;
                    gen_count_r <= gen_count_r + GEN_W'(1);
                    if (state_s == ST_IDLE) begin
                        single_r    <= 1'b0;
                        stop_pend_r <= 1'b0;
                    end else begin
                        timer_r <= PERIOD - 16'd1;
                    end
                end
                ST_WAIT: begin
                    if (!stop && (timer_r != 16'd0)) begin
                        timer_r <= timer_r - 16'd1;
                    end
                end
                default: begin
                    single_r <= single_r;
                end
            endcase
            disp_valid_r <= disp_gnt_s;
            if (disp_gnt_s) begin
                disp_data_r <= cur_rdata_s;
            end
        end
    end

    assign a_addr     = cur_bank_r ? nxt_addr_s  : cur_addr_s;
    assign a_we       = cur_bank_r ? nxt_we_s    : cur_we_s;
    assign a_wdata    = cur_bank_r ? nxt_wdata_s : cur_wdata_s;
    assign b_addr     = cur_bank_r ? cur_addr_s  : nxt_addr_s;
    assign b_we       = cur_bank_r ? cur_we_s    : nxt_we_s;
    assign b_wdata    = cur_bank_r ? cur_wdata_s : nxt_wdata_s;
    assign eng_rst    = eng_rst_s;
    assign eng_din    = eng_din_s;
    assign busy       = busy_s;
    assign disp_gnt   = disp_gnt_s;
    assign disp_data  = disp_data_r;
    assign disp_valid = disp_valid_r;
    assign cur_bank   = cur_bank_r;
    assign gen_count  = gen_count_r;

endmodule
